inst_decode: RTL and testbench
==============================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 The module SHALL have the following ports, in this order:
- ACLK  in  1  clock; all state changes on its rising edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- INST_VALID  in  1  fetch stage offers an instruction.
- INST  in  32  RV32I instruction word.
- INST_PC  in  32  address of INST.
- INST_READY  out  1  decode stage accepts the offered instruction.
- FLUSH  in  1  discard all held and offered instructions (branch redirect).
- DEC_VALID  out  1  decoded bundle is valid.
- DEC_READY  in  1  execute stage accepts the bundle.
- DEC_PC  out  32  PC of the bundle.
- DEC_RD, DEC_RS1, DEC_RS2  out  5 each  register indices.
- DEC_FUNCT3  out  3  instr[14:12].
- DEC_IMM  out  32  sign-extended immediate.
- DEC_ALUOP  out  4  ALU operation code from the package.
- DEC_CTRL  out  10  one-hot-ish flags {use_imm, reg_wr, mem_rd, mem_wr, branch, jal, jalr, lui, auipc, system}.
- DEC_ILLEGAL  out  1  the bundle's opcode or funct field is not RV32I.

Function
REQ-002 A transfer SHALL occur on a port when valid and ready are both 1 at a rising edge.
- Input: INST_VALID/INST_READY.
- Output: DEC_VALID/DEC_READY.
REQ-003 Latency SHALL be exactly 1 cycle from input accept to DEC_VALID=1, with full throughput of 1 instruction per cycle while DEC_READY=1.
REQ-004 Buffering SHALL be a main output register plus one skid register.
- INST_READY SHALL be registered and equal to "skid register empty".
- No instruction is lost or duplicated under any DEC_READY pattern.
REQ-005 When the output is stalled (DEC_VALID=1, DEC_READY=0) and an input is accepted, that input SHALL go to the skid register, and INST_READY SHALL be 0 on the next cycle.
REQ-006 When the output transfer completes and the skid register is full, the skid contents SHALL move to the main register and INST_READY SHALL return to 1 on the next cycle.
REQ-007 Decoded outputs SHALL be stable while DEC_VALID=1 and DEC_READY=0.
REQ-008 DEC_IMM SHALL be formed per format, sign bit instr[31]:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R-type: 0.
REQ-009 DEC_ALUOP SHALL select:
- OP/OP-IMM: from funct3 and instr[30]. instr[30] is used for OP-IMM only when funct3=101.
- Loads, stores, JAL, JALR, AUIPC, LUI: ADD.
- Branches: SUB.
REQ-010 For opcodes with no rd (STORE, BRANCH), DEC_CTRL.reg_wr SHALL be 0. When rd=0, reg_wr SHALL also be 0.
REQ-011 FLUSH=1 at a rising edge SHALL:
- clear the main and skid valid bits;
- discard any input offered in that cycle, even if INST_VALID=1 and INST_READY=1 (FLUSH wins).
On the next cycle, DEC_VALID SHALL be 0 and INST_READY SHALL be 1.
REQ-012 The state machine SHALL have two states, S_RUN and S_HALT:
- S_RUN to S_HALT: when a bundle with DEC_ILLEGAL=1 transfers out.
- In S_HALT: INST_READY=0.
- S_HALT to S_RUN: only on FLUSH.

Reset
REQ-013 When ARESETN=0, the module SHALL, asynchronously:
- set the state to S_RUN;
- clear the main and skid valid bits;
- drive INST_READY=1 after release;
- drive DEC_VALID=0 and DEC_ILLEGAL=0;
- drive all other outputs to 0.
REQ-014 Reset asserted mid-operation SHALL drop any held instructions without a DEC_VALID glitch after release.

Configuration
REQ-015 With macro INST_DECODE_ILLEGAL_CHECK_EN defined:
- unsupported opcodes, funct3 or funct7 values SHALL set DEC_ILLEGAL;
- S_HALT SHALL be used as specified in REQ-012.
REQ-016 Without INST_DECODE_ILLEGAL_CHECK_EN:
- DEC_ILLEGAL SHALL be tied to 0;
- an unknown instruction SHALL decode as a NOP (all DEC_CTRL bits 0);
- the state SHALL never leave S_RUN.

Structure
REQ-017 The shared package inst_decode_pkg SHALL hold:
- RV32I opcode constants;
- ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
- DEC_CTRL bit positions;
- state encodings.
REQ-018 Immediate generation SHALL be a combinational sub-module, imm_gen, instantiated once, ahead of the register stage.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- addi x1,x0,5: INST=0x00500093, PC=0x0 → one cycle later DEC_VALID=1, RD=1, RS1=0, IMM=5, ALUOP=ADD, use_imm=1, reg_wr=1.
- lui x2,0x12345: 0x12345137 → IMM=0x12345000, lui=1, RD=2. beq x0,x0,-4: 0xFE000EE3 → IMM=0xFFFFFFFC, branch=1, ALUOP=SUB, reg_wr=0.
- Back-to-back stream of 4 instructions with DEC_READY held low for 2 cycles mid-stream → INST_READY falls for exactly the full-skid cycles; the 4 bundles emerge in order, none dropped or repeated.
- FLUSH asserted together with INST_VALID=1 while both registers are full → next cycle DEC_VALID=0, INST_READY=1; the offered instruction never appears.
- With INST_DECODE_ILLEGAL_CHECK_EN: 0xFFFFFFFF → DEC_ILLEGAL=1; after its transfer INST_READY=0 until FLUSH. Without the macro: same input → DEC_CTRL=0, DEC_ILLEGAL=0, stream continues.
- ARESETN pulsed low mid-stream → all outputs 0 immediately; after release, INST_READY=1 and DEC_VALID=0.

Source files
------------

// File: rtl/inst_decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU ops, control flag positions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_t;

    // DEC_CTRL = {use_imm, reg_wr, mem_rd, mem_wr, branch, jal, jalr, lui, auipc, system}
    localparam int CTRL_W       = 10;
    localparam int CTRL_USE_IMM = 9;
    localparam int CTRL_REG_WR  = 8;
    localparam int CTRL_MEM_RD  = 7;
    localparam int CTRL_MEM_WR  = 6;
    localparam int CTRL_BRANCH  = 5;
    localparam int CTRL_JAL     = 4;
    localparam int CTRL_JALR    = 3;
    localparam int CTRL_LUI     = 2;
    localparam int CTRL_AUIPC   = 1;
    localparam int CTRL_SYSTEM  = 0;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [31:0]       imm;
        aluop_t            aluop;
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
    } dec_t;

    // ALU op for OP / OP-IMM; 'alt' is instr[30] where it is meaningful.
    function automatic aluop_t alu_sel(input logic [2:0] f3, input logic alt);
        aluop_t op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/inst_decode_imm_gen.sv
// Immediate generator: sign-extended immediate selected by the instruction format.
// Latency: combinational.
// Backpressure: none.
// Ports: inst (32b instruction word) -> imm (32b immediate, 0 for R-type/unknown).
module imm_gen
    import inst_decode_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: combinational decode into a main output register backed by one skid register.
// Latency: 1 cycle accept-to-DEC_VALID, 1 instr/cycle while DEC_READY=1.
// Backpressure: INST_READY is registered "skid empty" (and 0 while halted); FLUSH drops everything.
// Ports: ACLK/ARESETN; fetch side INST_VALID/INST/INST_PC/INST_READY; FLUSH; execute side
// DEC_VALID/DEC_READY plus decoded bundle DEC_PC/RD/RS1/RS2/FUNCT3/IMM/ALUOP/CTRL/ILLEGAL.
// Macro INST_DECODE_ILLEGAL_CHECK_EN: flag non-RV32I encodings and halt after one transfers out.
module inst_decode
    import inst_decode_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        INST_VALID,
    input  logic [31:0] INST,
    input  logic [31:0] INST_PC,
    output logic        INST_READY,
    input  logic        FLUSH,
    output logic        DEC_VALID,
    input  logic        DEC_READY,
    output logic [31:0] DEC_PC,
    output logic [4:0]  DEC_RD,
    output logic [4:0]  DEC_RS1,
    output logic [4:0]  DEC_RS2,
    output logic [2:0]  DEC_FUNCT3,
    output logic [31:0] DEC_IMM,
    output logic [3:0]  DEC_ALUOP,
    output logic [9:0]  DEC_CTRL,
    output logic        DEC_ILLEGAL
);

    logic [31:0] imm_w;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        known;
    logic        bad_funct;
    dec_t        dec_d;

    dec_t        main_q;
    dec_t        skid_q;
    logic        main_vld;
    logic        skid_vld;
    logic        skid_vld_nxt;
    logic        in_rdy_q;
    logic        in_fire;
    logic        out_fire;
    state_t      state_q;
    state_t      state_nxt;

    assign opc = INST[6:0];
    assign f3  = INST[14:12];
    assign f7  = INST[31:25];

    imm_gen u_imm_gen (
        .inst (INST),
        .imm  (imm_w)
    );

    always_comb begin
        dec_d        = '0;
        dec_d.pc     = INST_PC;
        dec_d.rd     = INST[11:7];
        dec_d.rs1    = INST[19:15];
        dec_d.rs2    = INST[24:20];
        dec_d.funct3 = f3;
        dec_d.imm    = imm_w;
        dec_d.aluop  = ALU_ADD;
        known        = 1'b1;
        bad_funct    = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                dec_d.ctrl[CTRL_LUI]     = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                dec_d.ctrl[CTRL_AUIPC]   = 1'b1;
            end
            OPC_JAL: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                dec_d.ctrl[CTRL_JAL]     = 1'b1;
            end
            OPC_JALR: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                dec_d.ctrl[CTRL_JALR]    = 1'b1;
                bad_funct = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_d.ctrl[CTRL_BRANCH] = 1'b1;
                dec_d.aluop = ALU_SUB;
                bad_funct = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                dec_d.ctrl[CTRL_MEM_RD]  = 1'b1;
                bad_funct = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_MEM_WR]  = 1'b1;
                bad_funct = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_d.ctrl[CTRL_USE_IMM] = 1'b1;
                dec_d.ctrl[CTRL_REG_WR]  = 1'b1;
                // instr[30] is immediate data except in the shift-right encodings
                dec_d.aluop = alu_sel(f3, (f3 == 3'b101) && f7[5]);
                bad_funct = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                            ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            end
            OPC_OP: begin
                dec_d.ctrl[CTRL_REG_WR] = 1'b1;
                dec_d.aluop = alu_sel(f3, f7[5]);
                bad_funct = !((f7 == 7'b0000000) ||
                              ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_MISC_MEM: begin
                bad_funct = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                dec_d.ctrl[CTRL_SYSTEM] = 1'b1;
                bad_funct = (f3 != 3'b000);
            end
            default: known = 1'b0;
        endcase
        // Writes to x0 are architecturally discarded; suppress them here.
        if (dec_d.rd == 5'd0) begin
            dec_d.ctrl[CTRL_REG_WR] = 1'b0;
        end
        // Anything not recognised becomes a NOP so downstream never acts on it.
        if (!known || bad_funct) begin
            dec_d.ctrl = '0;
        end
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
        dec_d.illegal = !known || bad_funct;
`else
        dec_d.illegal = 1'b0;
`endif
    end

    assign in_fire  = INST_VALID && in_rdy_q;
    assign out_fire = main_vld && DEC_READY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (FLUSH) begin
            state_nxt = S_RUN;
        end
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
        else if ((state_q == S_RUN) && out_fire && main_q.illegal) begin
            state_nxt = S_HALT;
        end
`endif
    end

    // Skid fills only when the main register is stalled; it drains as soon as main frees up.
    always_comb begin
        skid_vld_nxt = skid_vld;
        if (FLUSH || !main_vld || DEC_READY) begin
            skid_vld_nxt = 1'b0;
        end else if (in_fire) begin
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_rdy_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            skid_vld <= skid_vld_nxt;
            in_rdy_q <= (state_nxt == S_RUN) && !skid_vld_nxt;
            if (FLUSH) begin
                main_vld <= 1'b0;
            end else if (!main_vld || DEC_READY) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= in_fire;
                    if (in_fire) begin
                        main_q <= dec_d;
                    end
                end
            end else if (in_fire) begin
                skid_q <= dec_d;
            end
        end
    end

    assign INST_READY  = in_rdy_q;
    assign DEC_VALID   = main_vld;
    assign DEC_PC      = main_q.pc;
    assign DEC_RD      = main_q.rd;
    assign DEC_RS1     = main_q.rs1;
    assign DEC_RS2     = main_q.rs2;
    assign DEC_FUNCT3  = main_q.funct3;
    assign DEC_IMM     = main_q.imm;
    assign DEC_ALUOP   = main_q.aluop;
    assign DEC_CTRL    = main_q.ctrl;
    assign DEC_ILLEGAL = main_q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: decode vectors, skid stall stream, flush, illegal/halt, reset.
// Latency: n/a.
// Backpressure: driven by DEC_READY patterns below.
module tb_inst_decode;
    import inst_decode_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        INST_VALID = 1'b0;
    logic [31:0] INST = '0;
    logic [31:0] INST_PC = '0;
    logic        INST_READY;
    logic        FLUSH = 1'b0;
    logic        DEC_VALID;
    logic        DEC_READY = 1'b0;
    logic [31:0] DEC_PC;
    logic [4:0]  DEC_RD;
    logic [4:0]  DEC_RS1;
    logic [4:0]  DEC_RS2;
    logic [2:0]  DEC_FUNCT3;
    logic [31:0] DEC_IMM;
    logic [3:0]  DEC_ALUOP;
    logic [9:0]  DEC_CTRL;
    logic        DEC_ILLEGAL;

`ifdef INST_DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    always #5 ACLK = ~ACLK;

    inst_decode dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .INST_VALID  (INST_VALID),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_READY  (INST_READY),
        .FLUSH       (FLUSH),
        .DEC_VALID   (DEC_VALID),
        .DEC_READY   (DEC_READY),
        .DEC_PC      (DEC_PC),
        .DEC_RD      (DEC_RD),
        .DEC_RS1     (DEC_RS1),
        .DEC_RS2     (DEC_RS2),
        .DEC_FUNCT3  (DEC_FUNCT3),
        .DEC_IMM     (DEC_IMM),
        .DEC_ALUOP   (DEC_ALUOP),
        .DEC_CTRL    (DEC_CTRL),
        .DEC_ILLEGAL (DEC_ILLEGAL)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // addi x(k+1), x0, 16+k
    function automatic logic [31:0] sinst(input int k);
        return ((32'(16 + k)) << 20) | ((32'(k + 1)) << 7) | 32'h13;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [9:0]  ctrl;
    } vec_t;

    vec_t vt[7];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int   idx;
        int   oidx;
        logic in_f;
        logic [7:0] rpat;
        logic [7:0] rexp;

        vt[0] = '{32'h00500093, 32'h00000005, 5'd1,  4'd0, 10'h300}; // addi x1,x0,5
        vt[1] = '{32'h12345137, 32'h12345000, 5'd2,  4'd0, 10'h304}; // lui x2,0x12345
        vt[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 4'd1, 10'h020}; // beq x0,x0,-4
        vt[3] = '{32'h00000013, 32'h00000000, 5'd0,  4'd0, 10'h200}; // addi x0,x0,0
        vt[4] = '{32'h402081B3, 32'h00000000, 5'd3,  4'd1, 10'h100}; // sub x3,x1,x2
        vt[5] = '{32'hFE20AE23, 32'hFFFFFFFC, 5'd28, 4'd0, 10'h240}; // sw x2,-4(x1)
        vt[6] = '{32'h008000EF, 32'h00000008, 5'd1,  4'd0, 10'h310}; // jal x1,8

        // Reset state
        repeat (2) tick();
        chk("rst0_vld",  DEC_VALID, 0);
        chk("rst0_ill",  DEC_ILLEGAL, 0);
        chk("rst0_ctrl", DEC_CTRL, 0);
        chk("rst0_imm",  DEC_IMM, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        chk("rst0_rdy_after", INST_READY, 1);
        chk("rst0_vld_after", DEC_VALID, 0);

        // Decode vectors back to back
        DEC_READY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            INST_VALID = 1'b1;
            INST       = vt[i].inst;
            INST_PC    = 32'(i * 4);
            tick();
            chk("vec_vld",  DEC_VALID, 1);
            chk("vec_pc",   DEC_PC, 32'(i * 4));
            chk("vec_rd",   DEC_RD, vt[i].rd);
            chk("vec_imm",  DEC_IMM, vt[i].imm);
            chk("vec_alu",  DEC_ALUOP, vt[i].alu);
            chk("vec_ctrl", DEC_CTRL, vt[i].ctrl);
            chk("vec_ill",  DEC_ILLEGAL, 0);
            if (i == 0) chk("addi_rs1", DEC_RS1, 0);
            if (i == 4) chk("sub_rs2", DEC_RS2, 2);
            if (i == 5) chk("sw_f3", DEC_FUNCT3, 2);
        end
        INST_VALID = 1'b0;
        tick();
        chk("bubble_vld", DEC_VALID, 0);

        // Stream of 4 with DEC_READY low for 2 cycles
        rpat = 8'b1111_1001;
        rexp = 8'b1111_1001;
        idx  = 0;
        oidx = 0;
        for (int c = 0; c < 8; c++) begin
            INST_VALID = (idx < 4);
            INST       = sinst(idx);
            INST_PC    = 32'h100 + 32'(idx * 4);
            DEC_READY  = rpat[c];
            if (DEC_VALID && DEC_READY) begin
                chk("stream_imm", DEC_IMM, 32'(16 + oidx));
                chk("stream_pc",  DEC_PC, 32'h100 + 32'(oidx * 4));
                oidx++;
            end
            in_f = INST_VALID && INST_READY;
            tick();
            if (in_f) idx++;
            chk("stream_rdy", INST_READY, rexp[c]);
            if (c == 1 || c == 2) chk("stall_hold", DEC_IMM, 16);
        end
        chk("stream_count", oidx, 4);
        chk("stream_drain", DEC_VALID, 0);

        // Flush with both registers full
        DEC_READY  = 1'b0;
        INST_VALID = 1'b1;
        INST = vt[0].inst;
        tick();
        INST = vt[1].inst;
        tick();
        chk("full_rdy", INST_READY, 0);
        chk("full_vld", DEC_VALID, 1);
        FLUSH = 1'b1;
        INST  = vt[6].inst;
        tick();
        FLUSH = 1'b0;
        INST_VALID = 1'b0;
        chk("flush_vld", DEC_VALID, 0);
        chk("flush_rdy", INST_READY, 1);
        DEC_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_gone", DEC_VALID, 0);
        end

        // Flush wins over an accepted input
        DEC_READY  = 1'b0;
        INST_VALID = 1'b1;
        INST = vt[0].inst;
        tick();
        chk("flush2_rdy_pre", INST_READY, 1);
        FLUSH = 1'b1;
        INST  = vt[1].inst;
        tick();
        FLUSH = 1'b0;
        INST_VALID = 1'b0;
        chk("flush2_vld", DEC_VALID, 0);
        chk("flush2_rdy", INST_READY, 1);
        DEC_READY = 1'b1;
        tick();
        chk("flush2_gone", DEC_VALID, 0);

        // Illegal instruction
        INST_VALID = 1'b1;
        INST       = 32'hFFFFFFFF;
        INST_PC    = 32'h200;
        tick();
        chk("ill_vld",  DEC_VALID, 1);
        chk("ill_ctrl", DEC_CTRL, 0);
        chk("ill_flag", DEC_ILLEGAL, ILL_EXP);
        INST = vt[0].inst;
        tick();
        chk("post_ill_rdy", INST_READY, !ILL_EXP);
        chk("post_ill_vld", DEC_VALID, 1);
        chk("post_ill_imm", DEC_IMM, 5);
        INST = vt[6].inst;
        tick();
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
        chk("halt_vld", DEC_VALID, 0);
        chk("halt_rdy", INST_READY, 0);
        tick();
        chk("halt_rdy2", INST_READY, 0);
        FLUSH = 1'b1;
        INST_VALID = 1'b0;
        tick();
        FLUSH = 1'b0;
        chk("unhalt_rdy", INST_READY, 1);
`else
        chk("cont_vld", DEC_VALID, 1);
        chk("cont_imm", DEC_IMM, 8);
        INST_VALID = 1'b0;
        tick();
        chk("cont_rdy", INST_READY, 1);
`endif

        // Reset mid-stream with both registers full
        DEC_READY  = 1'b0;
        INST_VALID = 1'b1;
        INST = vt[1].inst;
        tick();
        INST = vt[2].inst;
        tick();
        chk("prerst_vld", DEC_VALID, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("rst_vld",  DEC_VALID, 0);
        chk("rst_pc",   DEC_PC, 0);
        chk("rst_imm",  DEC_IMM, 0);
        chk("rst_ctrl", DEC_CTRL, 0);
        chk("rst_rd",   DEC_RD, 0);
        chk("rst_alu",  DEC_ALUOP, 0);
        chk("rst_ill",  DEC_ILLEGAL, 0);
        INST_VALID = 1'b0;
        DEC_READY  = 1'b1;
        repeat (2) tick();
        chk("rst_hold_vld", DEC_VALID, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        chk("rel_vld", DEC_VALID, 0);
        chk("rel_rdy", INST_READY, 1);
        tick();
        chk("rel_vld2", DEC_VALID, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
